bomb_game_tx: RTL

Stimulus transmitter for the bomb-grid game interface. On `start`, it builds an 8×8 block/bomb board and 10 hit coordinates from a 16-bit LFSR, then streams them on the game input protocol: rows on `in_valid1`, hits on `in_valid2`. It then waits for the game engine's single-cycle `out_valid` and captures the destroyed-block count. It sits between the self-test controller and the game engine, driving the same ports the engine receives.

---
 rtl/bomb_game_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bomb_game_tx.sv
// bomb_game_tx: builds an LFSR board/hit game, streams it to the engine, then captures the engine's response.
module bomb_game_tx #(
    parameter logic [4:0] TIMEOUT = 5'd31
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [15:0] seed_i,
    output logic [7:0]  in_o,
    output logic [7:0]  bomb_o,
    output logic        in_valid1_o,
    output logic [5:0]  hit_o,
    output logic        in_valid2_o,
    input  logic        dut_out_valid_i,
    input  logic [6:0]  dut_out_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [6:0]  result_o,
    output logic [6:0]  blk_total_o,
    output logic        timeout_o,
    output logic        range_err_o
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;
    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  wcnt_q, wcnt_d;
    logic [7:0]  in_q, in_d, bomb_q, bomb_d;
    logic [5:0]  hit_q, hit_d;
    logic        iv1_q, iv1_d, iv2_q, iv2_d;
    logic [6:0]  result_q, result_d, blk_q, blk_d;
    logic        timeout_q, timeout_d, rerr_q, rerr_d;
    logic [3:0]  pc;
    logic        fb;
    assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    always_comb begin
        pc = '0;
        for (int i = 0; i < 8; i++) pc = pc + {3'b0, lfsr_q[i]};
    end
    // Beat outputs are computed from the pre-step LFSR and registered, so they trail the state by one cycle.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        in_d      = '0;
        bomb_d    = '0;
        hit_d     = '0;
        iv1_d     = 1'b0;
        iv2_d     = 1'b0;
        result_d  = result_q;
        blk_d     = blk_q;
        timeout_d = timeout_q;
        rerr_d    = rerr_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d   = SEND;
                lfsr_d    = (seed_i == 16'h0) ? 16'hACE1 : seed_i;
                cnt_d     = '0;
                blk_d     = '0;
                timeout_d = 1'b0;
                rerr_d    = 1'b0;
            end
            SEND: begin
                lfsr_d = {lfsr_q[14:0], fb};
                cnt_d  = cnt_q + 4'd1;
                wcnt_d = '0;
                iv2_d  = 1'b1;
                hit_d  = lfsr_q[5:0];
                if (!cnt_q[3]) begin
                    iv1_d  = 1'b1;
                    in_d   = lfsr_q[7:0];
                    bomb_d = lfsr_q[15:8] & lfsr_q[7:0];
                    blk_d  = blk_q + {3'b0, pc};
                end
                if (cnt_q == 4'd9) state_d = WAIT;
            end
            WAIT: begin
                wcnt_d = wcnt_q + 5'd1;
                if (dut_out_valid_i) begin
                    result_d  = dut_out_i;
                    rerr_d    = dut_out_i > blk_q;
                    timeout_d = 1'b0;
                    state_d   = DONE;
                end else if (wcnt_q == TIMEOUT) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            lfsr_q    <= 16'hACE1;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            in_q      <= '0;
            bomb_q    <= '0;
            hit_q     <= '0;
            iv1_q     <= 1'b0;
            iv2_q     <= 1'b0;
            result_q  <= '0;
            blk_q     <= '0;
            timeout_q <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            in_q      <= in_d;
            bomb_q    <= bomb_d;
            hit_q     <= hit_d;
            iv1_q     <= iv1_d;
            iv2_q     <= iv2_d;
            result_q  <= result_d;
            blk_q     <= blk_d;
            timeout_q <= timeout_d;
            rerr_q    <= rerr_d;
        end
    end
    assign in_o        = in_q;
    assign bomb_o      = bomb_q;
    assign hit_o       = hit_q;
    assign in_valid1_o = iv1_q;
    assign in_valid2_o = iv2_q;
    assign busy_o      = (state_q == SEND) || (state_q == WAIT);
    assign done_o      = state_q == DONE;
    assign result_o    = result_q;
    assign blk_total_o = blk_q;
    assign timeout_o   = timeout_q;
    assign range_err_o = rerr_q;
endmodule
